// File: rtl/tick_sched_pkg.sv
// Shared constants and types for the tick scheduler: channel modes, channel
// states and the default prescale ratio (100 MHz -> 1 ms base tick).
package tick_sched_pkg;

  localparam int DEFAULT_CLK_RATIO = 100000;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  // Channel index width for a given channel count, never less than one bit.
  function automatic int ch_idx_width(input int n_ch);
    int w;
    w = $clog2(n_ch);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider of i_CLK producing a single-cycle base-tick enable.
// It never generates a clock; the count freezes while i_PAUSE is high.
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int CLK_RATIO = DEFAULT_CLK_RATIO
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_PAUSE,
  output logic o_TICK
);

  localparam int PW = (CLK_RATIO > 2) ? $clog2(CLK_RATIO) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_RATIO - 1);

  logic [PW-1:0] count_r;
  logic [PW-1:0] count_s;

  // Next prescaler count: hold on pause, wrap after the last phase.
  always_comb begin
    count_s = count_r;
    if (i_PAUSE) begin
      count_s = count_r;
    end else if (count_r == LAST) begin
      count_s = '0;
    end else begin
      count_s = count_r + PW'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      count_r <= '0;
    end else begin
      count_r <= count_s;
    end
  end

  // Tick is qualified by the live pause/reset inputs so it drops in the same cycle.
  assign o_TICK = !i_RST && !i_PAUSE && (count_r == LAST);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel countdown scheduler driven by one shared base-tick enable.
// Each channel counts base ticks and emits a one-cycle expiry pulse.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int CLK_RATIO = DEFAULT_CLK_RATIO,
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int CH_W      = 2
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_PAUSE,
  input  logic             i_CFG_WE,
  input  logic [CH_W-1:0]  i_CFG_CH,
  input  logic [CNT_W-1:0] i_CFG_PERIOD,
  input  logic             i_CFG_MODE,
  input  logic             i_CFG_START,
  output logic             o_TICK,
  output logic [N_CH-1:0]  o_EXPIRE,
  output logic [N_CH-1:0]  o_BUSY,
  output logic             o_CFG_ERR
);

  logic        tick_s;
  logic [31:0] ch_ext_s;
  logic        ch_valid_s;
  logic        reject_s;
  logic        accept_s;
  logic        err_r;

  tick_prescaler #(
    .CLK_RATIO(CLK_RATIO)
  ) u_prescaler (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_PAUSE(i_PAUSE),
    .o_TICK (tick_s)
  );

  assign o_TICK     = tick_s;
  assign ch_ext_s   = 32'(i_CFG_CH);
  assign ch_valid_s = (ch_ext_s < 32'(N_CH));
  // Starting with a zero period would never expire, so it is refused like a bad index.
  assign reject_s   = i_CFG_WE && (!ch_valid_s || (i_CFG_START && (i_CFG_PERIOD == '0)));
  assign accept_s   = i_CFG_WE && !reject_s;

  // Error pulse register, one cycle after a refused write.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      err_r <= 1'b0;
    end else begin
      err_r <= reject_s;
    end
  end

  assign o_CFG_ERR = err_r;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic             hit_s;
    ch_state_t        state_r;
    ch_state_t        state_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] period_s;
    logic [CNT_W-1:0] remain_r;
    logic [CNT_W-1:0] remain_s;
    logic             mode_r;
    logic             mode_s;
    logic             expire_r;
    logic             expire_s;

    assign hit_s = accept_s && (ch_ext_s == 32'(k));

    // Channel next state: an accepted write wins over a coincident tick.
    always_comb begin
      state_s  = state_r;
      period_s = period_r;
      remain_s = remain_r;
      mode_s   = mode_r;
      expire_s = 1'b0;
      if (hit_s) begin
        period_s = i_CFG_PERIOD;
        mode_s   = i_CFG_MODE;
        if (i_CFG_START) begin
          state_s  = RUN;
          remain_s = i_CFG_PERIOD;
        end else begin
          state_s  = IDLE;
          remain_s = '0;
        end
      end else begin
        case (state_r)
          RUN: begin
            if (!tick_s) begin
              remain_s = remain_r;
            end else if (remain_r <= CNT_W'(1)) begin
              expire_s = 1'b1;
              if (mode_r == MODE_PERIODIC) begin
                remain_s = period_r;
              end else begin
                state_s  = IDLE;
                remain_s = '0;
              end
            end else begin
              remain_s = remain_r - CNT_W'(1);
            end
          end
          IDLE: begin
            remain_s = remain_r;
          end
          default: begin
            state_s  = IDLE;
            remain_s = '0;
          end
        endcase
      end
    end

    // Channel registers, including the registered expiry pulse.
    always_ff @(posedge i_CLK) begin
      if (i_RST) begin
        state_r  <= IDLE;
        period_r <= '0;
        remain_r <= '0;
        mode_r   <= MODE_ONESHOT;
        expire_r <= 1'b0;
      end else begin
        state_r  <= state_s;
        period_r <= period_s;
        remain_r <= remain_s;
        mode_r   <= mode_s;
        expire_r <= expire_s;
      end
    end

    assign o_BUSY[k]   = (state_r == RUN);
    assign o_EXPIRE[k] = expire_r;
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: config table, directed timing
// sequences and a randomized run against a tick-counting reference model.
module tb_tick_scheduler;

  localparam int CR  = 4;
  localparam int NCH = 4;
  localparam int CW  = 6;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           rst, pause, we, mode, start;
  logic [CHW-1:0] ch;
  logic [CW-1:0]  per;
  logic           tick, err;
  logic [NCH-1:0] exp_o, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tick_scheduler #(.CLK_RATIO(CR), .N_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
    .i_CLK(clk), .i_RST(rst), .i_PAUSE(pause), .i_CFG_WE(we), .i_CFG_CH(ch),
    .i_CFG_PERIOD(per), .i_CFG_MODE(mode), .i_CFG_START(start),
    .o_TICK(tick), .o_EXPIRE(exp_o), .o_BUSY(busy), .o_CFG_ERR(err)
  );

  // Reference model: unpaused-cycle counter and per-channel ticks-left counts.
  int             act = 0;
  bit             m_run  [NCH];
  int             m_per  [NCH];
  bit             m_mode [NCH];
  int             m_left [NCH];
  bit [NCH-1:0]   m_exp = '0;
  bit             m_err = 1'b0;
  bit             s_tick;

  typedef struct {
    int ch; int per; bit mode; bit start; bit err; int busy;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit model_tick();
    return !rst && !pause && ((act % CR) == CR - 1);
  endfunction

  function automatic int model_busy();
    int b = 0;
    for (int k = 0; k < NCH; k++) if (m_run[k]) b |= (1 << k);
    return b;
  endfunction

  task automatic model_update(input bit t);
    bit rej;
    rej = we && ((int'(ch) >= NCH) || (start && (per == 0)));
    if (rst) begin
      act = 0;
      for (int k = 0; k < NCH; k++) begin
        m_run[k] = 0; m_per[k] = 0; m_mode[k] = 0; m_left[k] = 0;
      end
      m_exp = '0;
      m_err = 1'b0;
    end else begin
      m_exp = '0;
      for (int k = 0; k < NCH; k++) begin
        if (we && !rej && int'(ch) == k) begin
          m_per[k]  = int'(per);
          m_mode[k] = mode;
          m_run[k]  = start;
          m_left[k] = start ? int'(per) : 0;
        end else if (m_run[k] && t) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_exp[k] = 1'b1;
            if (m_mode[k]) m_left[k] = m_per[k];
            else m_run[k] = 0;
          end
        end
      end
      if (!pause) act++;
      m_err = rej;
    end
  endtask

  // One clock: tick sampled mid-cycle, registered outputs #1 after the edge.
  task automatic cycle();
    bit mt;
    #4;
    mt = model_tick();
    s_tick = tick;
    chk("tick", int'(tick), int'(mt));
    @(posedge clk);
    model_update(mt);
    #1;
    chk("expire", int'(exp_o), int'(m_exp));
    chk("busy", int'(busy), model_busy());
    chk("cfg_err", int'(err), int'(m_err));
  endtask

  task automatic wr(input int c, input int p, input bit md, input bit st);
    we = 1'b1; ch = CHW'(c); per = CW'(p); mode = md; start = st;
    cycle();
    we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int ticks, cyc, last, n, cnt;

    tbl[0] = '{2, 0,  1'b0, 1'b1, 1'b1, 0};
    tbl[1] = '{5, 3,  1'b1, 1'b1, 1'b1, 0};
    tbl[2] = '{0, 3,  1'b1, 1'b1, 1'b0, 1};
    tbl[3] = '{1, 2,  1'b0, 1'b1, 1'b0, 3};
    tbl[4] = '{2, 0,  1'b1, 1'b1, 1'b1, 3};
    tbl[5] = '{7, 1,  1'b0, 1'b1, 1'b1, 3};
    tbl[6] = '{0, 0,  1'b0, 1'b0, 1'b0, 2};
    tbl[7] = '{3, 63, 1'b1, 1'b1, 1'b0, 10};
    tbl[8] = '{3, 5,  1'b0, 1'b0, 1'b0, 2};
    tbl[9] = '{1, 4,  1'b0, 1'b0, 1'b0, 0};

    rst = 1'b1; pause = 1'b0; we = 1'b0; ch = '0; per = '0; mode = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_busy", int'(busy), 0);
    chk("rst_exp", int'(exp_o), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;

    // Idle run: tick on every fourth cycle, nothing else moves.
    for (int i = 0; i < 16; i++) begin
      cycle();
      chk("idle_tick", int'(s_tick), int'((i % CR) == CR - 1));
      chk("idle_busy", int'(busy), 0);
    end

    // Config table applied under pause.
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].ch, tbl[i].per, tbl[i].mode, tbl[i].start);
      chk("tbl_err", int'(err), int'(tbl[i].err));
      chk("tbl_busy", int'(busy), tbl[i].busy);
      chk("tbl_exp", int'(exp_o), 0);
    end
    pause = 1'b0;

    // Periodic ch0, period 3: pulses 12 clocks apart.
    wr(0, 3, 1'b1, 1'b1);
    chk("per_busy", int'(busy[0]), 1);
    last = -1; n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      cycle();
      if (exp_o[0]) begin
        if (last >= 0) chk("per_gap", c - last, 12);
        last = c; n++;
      end
    end
    chk("per_count", n, 6);

    // Stop ch0 mid-count: no expiry afterwards.
    for (int i = 0; i < 5; i++) cycle();
    wr(0, 3, 1'b1, 1'b0);
    chk("stop_busy", int'(busy[0]), 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (exp_o[0]) cnt++;
    end
    chk("stop_noexp", cnt, 0);

    // One-shot ch1, period 2.
    wr(1, 2, 1'b0, 1'b1);
    chk("os_busy_start", int'(busy[1]), 1);
    ticks = 0;
    for (int c = 0; c < 100 && ticks < 2; c++) begin
      cycle();
      if (s_tick) begin
        ticks++;
        chk("os_exp", int'(exp_o[1]), int'(ticks == 2));
        chk("os_busy", int'(busy[1]), int'(ticks < 2));
      end
    end
    chk("os_ticks", ticks, 2);
    cnt = 0;
    for (int i = 0; i < 20 * CR; i++) begin
      cycle();
      if (exp_o[1]) cnt++;
    end
    chk("os_extra", cnt, 0);

    // Restart ch0 on the very tick where it would expire.
    wr(0, 3, 1'b1, 1'b1);
    ticks = 0;
    for (int c = 0; c < 100 && ticks < 2; c++) begin
      cycle();
      if (s_tick) ticks++;
    end
    chk("rs_ticks", ticks, 2);
    for (int i = 0; i < CR - 1; i++) cycle();
    wr(0, 3, 1'b1, 1'b1);
    chk("rs_align", int'(s_tick), 1);
    chk("rs_noexp", int'(exp_o[0]), 0);
    chk("rs_busy", int'(busy[0]), 1);
    ticks = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      cycle();
      if (s_tick) ticks++;
      if (exp_o[0]) done = 1'b1;
    end
    chk("rs_full", ticks, 3);

    // Pause of 10 cycles delays the next expiry by exactly 10 cycles.
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      cycle();
      if (exp_o[0]) done = 1'b1;
    end
    chk("pz_sync", int'(done), 1);
    for (int i = 0; i < 3; i++) cycle();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("pz_tick", int'(s_tick), 0);
    end
    pause = 1'b0;
    cyc = 13; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      cycle();
      cyc++;
      if (exp_o[0]) done = 1'b1;
    end
    chk("pz_gap", cyc, 22);

    // Two channels aligned: simultaneous expiry.
    pause = 1'b1;
    wr(0, 2, 1'b1, 1'b1);
    wr(1, 2, 1'b1, 1'b1);
    pause = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      cycle();
      if (exp_o != '0) begin
        done = 1'b1;
        chk("sim_exp", int'(exp_o), 3);
      end
    end
    chk("sim_seen", int'(done), 1);

    // Reset mid-count with ch0/ch1 running.
    for (int i = 0; i < 5; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_exp", int'(exp_o), 0);
    chk("mrst_err", int'(err), 0);
    for (int i = 0; i < CR; i++) begin
      cycle();
      chk("mrst_tick", int'(s_tick), int'(i == CR - 1));
    end

    // All-ones period on ch3, one-shot.
    wr(3, 63, 1'b0, 1'b1);
    ticks = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      cycle();
      if (s_tick) ticks++;
      if (exp_o[3]) begin
        done = 1'b1;
        chk("max_busy", int'(busy[3]), 0);
      end
    end
    chk("max_per", ticks, 63);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      pause = ($urandom_range(0, 9) == 0);
      we    = ($urandom_range(0, 7) == 0);
      ch    = CHW'($urandom_range(0, 7));
      per   = CW'($urandom_range(0, 7));
      mode  = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
Multi-channel timer scheduler built on one shared prescaler. The prescaler divides i_CLK into a single-cycle base-tick enable (default 1 ms at 100 MHz). It never produces a derived clock. N_CH independently configurable countdown channels share that tick and emit one-cycle expiry pulses, one-shot or periodic. Sits between control FSMs (display scan, debounce, program timing) and all slow-rate sequencing in the design, so every consumer stays on i_CLK.

Parameters:
CLK_RATIO, 100000, i_CLK cycles per base tick (>=2)
N_CH, 4, number of countdown channels (1..16)
CNT_W, 16, width of channel period/remaining counters
CH_W, 2, channel index width, = max(1, clog2(N_CH))

Ports:
i_CLK  in  1  system clock
i_RST  in  1  synchronous reset, active-high
i_PAUSE  in  1  freezes prescaler and all channel countdowns while high
i_CFG_WE  in  1  config write strobe, one cycle
i_CFG_CH  in  CH_W  target channel of write
i_CFG_PERIOD  in  CNT_W  period in base ticks
i_CFG_MODE  in  1  0 = one-shot, 1 = periodic
i_CFG_START  in  1  1 = start/restart channel, 0 = stop channel
o_TICK  out  1  base-tick pulse, one cycle
o_EXPIRE  out  N_CH  per-channel expiry pulse, one cycle
o_BUSY  out  N_CH  channel running
o_CFG_ERR  out  1  one-cycle pulse on rejected write

Behaviour:
- Reset: already decided — reset i_RST, synchronous, active-high; clock i_CLK. In reset: prescaler count = 0, o_TICK = 0, o_EXPIRE = 0, o_BUSY = 0, o_CFG_ERR = 0, all periods/remaining = 0, all channels IDLE. Reset has priority over every input and aborts all running channels.
- Prescaler: count runs 0..CLK_RATIO-1 and wraps. o_TICK = 1 exactly in the cycle where count == CLK_RATIO-1 and i_PAUSE = 0. With i_PAUSE = 1, count holds and o_TICK = 0. Period = CLK_RATIO cycles, duty 1/CLK_RATIO.
- Channel states: IDLE and RUN. o_BUSY[k] = (state == RUN).
- IDLE -> RUN: on a write with START = 1 and PERIOD != 0. Stores period and mode; remaining <= PERIOD.
- RUN -> RUN restart: a write with START = 1 to a running channel reloads remaining. No expire is emitted for the aborted interval.
- any -> IDLE: a write with START = 0 stops the channel. Period and mode are stored; no expire; no error.
- Rejected write: START = 1 with PERIOD = 0, or i_CFG_CH >= N_CH. o_CFG_ERR pulses the next cycle. Channel state is unchanged.
- Countdown: in RUN, each o_TICK decrements remaining.
- Expiry: on the tick where remaining == 1, o_EXPIRE[k] is registered high for the following cycle (latency 1 after o_TICK). Then:
  - periodic: remaining <= period, stays RUN;
  - one-shot: -> IDLE, o_BUSY drops in the same cycle o_EXPIRE is high.
- First interval after start = PERIOD ticks. Its length in clocks is (PERIOD-1)*CLK_RATIO+1 .. PERIOD*CLK_RATIO depending on prescaler phase. Writes do not resynchronise the prescaler.
- Write and tick in the same cycle on the target channel: write wins, tick ignored for that channel. Other channels consume the tick normally.
- Multiple channels may expire in the same cycle; all bits assert together.
- Writes are accepted while i_PAUSE = 1. Counting resumes from the held values when pause drops.
- remaining never underflows or wraps; a period of all-ones is legal (2^CNT_W-1 ticks).

Decomposition:
- Package tick_sched_pkg: mode constants (MODE_ONESHOT = 0, MODE_PERIODIC = 1), channel state enum (IDLE, RUN), default CLK_RATIO constant for 100 MHz -> 1 ms.
- Sub-module tick_prescaler (params CLK_RATIO; ports i_CLK, i_RST, i_PAUSE, o_TICK). Replaces toggled divided clocks with an enable pulse.
- Channel logic is a generate loop in the top; no further sub-modules.

Test Plan:
- CLK_RATIO=4, reset released, no writes -> o_TICK high 1 cycle in every 4 (count 3); o_EXPIRE = 0 and o_BUSY = 0 throughout.
- CLK_RATIO=4, write ch0 PERIOD=3 MODE=1 START=1 -> o_BUSY[0] = 1 next cycle; o_EXPIRE[0] pulses 1 cycle after every 3rd tick (every 12 clocks); 5 consecutive pulses checked.
- Write ch1 PERIOD=2 MODE=0 -> single o_EXPIRE[1] one cycle after the 2nd tick; o_BUSY[1] falls the same cycle; no further pulses over 20 ticks.
- Write ch2 PERIOD=0 START=1, then CH=5 with N_CH=4 -> o_CFG_ERR pulses once per write; o_BUSY unchanged. Write ch0 START=0 mid-count -> o_BUSY[0] = 0 and no expire.
- Restart ch0 on the exact tick cycle with remaining=1 -> no expire; full new PERIOD counted. Hold i_PAUSE 10 cycles -> o_TICK absent and expiry delayed by exactly 10 cycles.
- Assert i_RST mid-count with ch0 and ch1 running -> next cycle all outputs 0 and prescaler restarts at 0; first post-reset tick arrives after CLK_RATIO cycles.
